// File: rtl/fxp32s_shift_arbiter_if.sv
// Request/response bundle between the fixed-point lanes and the shared shifter arbiter.
// master = requester side, slave = arbiter side.
interface fxp32s_shift_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_data;
  logic [32*N-1:0] req_shift;
  logic [N-1:0]    req_sign;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_data;

  modport master (
    output req_valid, req_data, req_shift, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_shift, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fxp32s_shift_arbiter.sv
// Round-robin arbiter sharing one fxp32s (sign-magnitude) variable shifter among N lanes,
// with an operand stage (S1) and a result stage (S2) feeding one tagged response channel.
module fxp32s_shift_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fxp32s_shift_arbiter_if.slave bus,
  output logic                  o_busy
);

  logic [IDW-1:0] r_ptr;
  logic           r_s1_v;
  logic [IDW-1:0] r_s1_id;
  logic [31:0]    r_s1_data;
  logic [31:0]    r_s1_shift;
  logic           r_s1_sign;
  logic           r_s2_v;
  logic [IDW-1:0] r_s2_id;
  logic [31:0]    r_s2_data;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_accept;
  logic [2*N-1:0] w_rot;
  logic           w_found;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW-1:0] w_ptr_nxt;
  logic [31:0]    w_sel_data;
  logic [31:0]    w_sel_shift;
  logic           w_sel_sign;
  logic [N-1:0]   w_req_ready;

  // Magnitude bits shift, sign bit is kept; any shift of 32 or more collapses to +0.
  function automatic logic [31:0] fxp_shift(input logic [31:0] d, input logic [31:0] s,
                                            input logic g);
    logic [61:0] ext;
    logic [30:0] mag;
    logic [31:0] res;
    ext = {{31{d[31]}}, d[30:0]};
    if (s[31:5] != 27'd0) begin
      res = 32'd0;
    end else if (g) begin
      mag = 31'(ext >> s[4:0]);
      res = {d[31], mag};
    end else begin
      mag = d[30:0] << s[4:0];
      res = {d[31], mag};
    end
    return res;
  endfunction

  assign w_s2_adv = ~r_s2_v | bus.rsp_ready;
  assign w_s1_adv = r_s1_v & w_s2_adv;
  assign w_accept = ~i_rst & (|bus.req_valid) & (~r_s1_v | w_s2_adv);

  // Rotating the doubled request vector by ptr turns the wrap-around search into a plain
  // lowest-set-bit search; the offset is then folded back modulo N.
  assign w_rot = {bus.req_valid, bus.req_valid} >> r_ptr;

  // First requester at or after ptr
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt_idx = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : IDW'(w_sum);
  assign w_ptr_nxt = (w_gnt_idx == IDW'(N-1)) ? '0 : w_gnt_idx + IDW'(1);

  // Operand mux and one-hot ready for the granted requester
  always_comb begin
    w_sel_data  = 32'd0;
    w_sel_shift = 32'd0;
    w_sel_sign  = 1'b0;
    w_req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_sel_data     = bus.req_data[32*i +: 32];
        w_sel_shift    = bus.req_shift[32*i +: 32];
        w_sel_sign     = bus.req_sign[i];
        w_req_ready[i] = w_accept;
      end else begin
        w_req_ready[i] = 1'b0;
      end
    end
  end

  // Pointer, operand stage and result stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_s1_v     <= 1'b0;
      r_s1_id    <= '0;
      r_s1_data  <= 32'd0;
      r_s1_shift <= 32'd0;
      r_s1_sign  <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s2_id    <= '0;
      r_s2_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_s1_v     <= 1'b1;
        r_s1_id    <= w_gnt_idx;
        r_s1_data  <= w_sel_data;
        r_s1_shift <= w_sel_shift;
        r_s1_sign  <= w_sel_sign;
        r_ptr      <= w_ptr_nxt;
      end else if (w_s1_adv) begin
        r_s1_v <= 1'b0;
      end
      if (w_s2_adv) begin
        r_s2_v    <= r_s1_v;
        r_s2_id   <= r_s1_id;
        r_s2_data <= fxp_shift(r_s1_data, r_s1_shift, r_s1_sign);
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_s2_v;
  assign bus.rsp_id    = r_s2_id;
  assign bus.rsp_data  = r_s2_data;
  assign o_busy        = r_s1_v | r_s2_v;

endmodule

// File: doc/fxp32s_shift_arbiter.md
# fxp32s_shift_arbiter

Round-robin arbiter and two-stage pipeline controller that shares a single fxp32s variable shifter between `N` requesters. Each requester issues a shift request over a valid/ready handshake. The block grants one request per cycle, registers the operands, and applies the shared shifter. Results return on a single valid/ready response channel, tagged with the requester id. It sits between the fixed-point compute lanes and the one physical shifter instance, so the lanes do not each need their own barrel shifter.

## Interface
- `N`, default 4: number of requesters (2..8).
- `IDW`, default 2: id width, equal to `$clog2(N)`.
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N: per-requester request valid.
- `req_ready`  out  N: per-requester accept. At most one bit is high in any cycle.
- `req_data`  in  32*N: operand for requester i, in bits [32i+31:32i]. Format is fxp32s: sign-magnitude, sign at bit 31, LSB weight 2^-24.
- `req_shift`  in  32*N: unsigned shift amount for requester i.
- `req_sign`  in  N: shift direction. 0 means left shift, 1 means right shift.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: result accept.
- `rsp_id`  out  IDW: index of the requester that owns the result.
- `rsp_data`  out  32: shifted result.
- `busy`  out  1: high when either pipeline stage holds a valid entry.

## Operation
- Shared shifter function, applied to operand `d`, shift `s` and direction `g`:
  - Saturation: if `s[31:5] != 0`, the result is 0x00000000, including bit 31.
  - Otherwise, bit 31 of the result is `d[31]`.
  - Otherwise, bits [30:0] of the result are bits [30:0] of `d` shifted by `s[4:0]`:
    - left shift (`g=0`) is logical and zero-fills;
    - right shift (`g=1`) is arithmetic and fills with `d[31]`.
- Stage 1 (S1) register holds: `s1_v`, id, data, shift and sign.
- Stage 2 (S2) register holds: `s2_v`, id, and the shifter result computed from S1.
- Advance conditions:
  - `s2_adv = !s2_v | rsp_ready`.
  - `s1_adv = s1_v & s2_adv`.
  - `accept = |req_valid & (!s1_v | s2_adv)`.
- Arbitration:
  - A round-robin pointer `ptr` (IDW bits) selects the search order.
  - The grant goes to the first i with `req_valid[i]`, searching in order ptr, ptr+1, …, N-1, 0, …, wrapping modulo N.
  - `req_ready[i] = accept & grant[i]`. It is combinational from `req_valid` and state.
  - Requesters must not make `req_valid` depend on `req_ready`.
- A handshake completes when `req_valid[i] & req_ready[i]`. On that edge:
  - S1 loads the operands of requester i and sets `s1_v=1`;
  - `ptr` becomes (i+1) mod N.
- If no request is accepted, `ptr` holds its value.
- On `s2_adv`:
  - S2 loads the result of S1 and sets `s2_v = s1_v`;
  - otherwise S2 holds.
- If `s1_adv` is high and no request is accepted, S1 clears `s1_v`.
- Output mapping: `rsp_valid = s2_v`, and `rsp_id` / `rsp_data` come from S2.
- While `rsp_valid=1 & rsp_ready=0`, `rsp_data` and `rsp_id` stay stable.
- `busy = s1_v | s2_v`.
- Requester operands are sampled only on the accept edge. They may change freely afterwards.

## Timing
- Reset values:
  - outputs: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `busy=0`;
  - internal: `ptr=0`, `s1_v=0`, `s2_v=0`.
- Reset asserted mid-operation clears all in-flight entries immediately, asynchronously.
- Those in-flight entries are dropped and never presented.
- The first grant after reset release searches from requester 0.
- Latency: a request accepted on edge k produces `rsp_valid` high after edge k+1. That is 2 cycles, provided no back-pressure is applied.
- Throughput: one accept per cycle while `rsp_ready=1`.
- Back-pressure:
  - With `rsp_ready=0` and S2 full, S1 can still accept one request.
  - With S1 and S2 both full, `req_ready` stays 0.
  - The first cycle `rsp_ready` returns, an accept is allowed in that same cycle, because S1 is advancing.
- A single active requester is granted every cycle, with no bubble.
- Simultaneous response drain and new accept in the same cycle is legal. No entry is lost and none is duplicated.

## Test plan
- Single request, left shift: req0 sends data 0x01000000, shift 3, sign 0 -> `req_ready[0]` high that cycle; 2 cycles later `rsp_valid=1`, `rsp_id=0`, `rsp_data=0x08000000`.
- Signed shifts:
  - req2 sends 0x80000010, shift 4, sign 1 -> `rsp_data=0xF8000001`, `rsp_id=2`.
  - 0x80000003, shift 1, sign 0 -> `rsp_data=0x80000006`.
- Saturation:
  - shift 32 on 0x80FFFFFF -> `rsp_data=0x00000000`;
  - shift 31 with sign 1 on 0x80000000 -> `rsp_data=0xFFFFFFFF`.
- Contention: all 4 requesters hold `req_valid` for 8 cycles with `rsp_ready=1` -> grant order is 0,1,2,3,0,1,2,3; `rsp_id` follows the same sequence 2 cycles later.
- Back-pressure:
  - Hold `rsp_ready=0` for 5 cycles with req1 and req3 valid.
  - Required: exactly 2 accepts occur, then `req_ready=0` and `busy=1`.
  - `rsp_data`/`rsp_id` stay stable while stalled.
  - On release, both results drain in order (ids 1, 3) and no results are duplicated.
- Reset mid-operation: assert `rst` with S1 and S2 full -> `rsp_valid` and `busy` go to 0 immediately; after release, no stale result appears; the next request from requester 0 or 3 is granted starting at `ptr=0`.
